// File: rtl/gated_delay_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gated_delay_mux_pkg                                                        |
// | Shared types and defaults for the gated delay mux.                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gated_delay_mux_pkg;

  localparam int CNT_W     = 8;
  localparam int DEF_W     = 8;
  localparam int DEF_NCH   = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_HOLD  = 3;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    BLANK = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gdm_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gdm_delay_line                                                             |
// | Fixed-depth shift register with synchronous clear; o_q is the tail stage.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gdm_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/gated_delay_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gated_delay_mux                                                            |
// | Delayed channel mux with cond-driven output blanking.                      |
// | Option macro GATED_DELAY_MUX_HOLD_EN: blanking held HOLD cycles after cond.|
// | Taint: in_data, cond are sources; out_data is the sink; cond, state sanit. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gated_delay_mux
  import gated_delay_mux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NCH   = DEF_NCH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NCH*W-1:0]         in_data,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic                     cond,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     blanked
);

  localparam int c_sel_w = $clog2(NCH);

  if (NCH < 2) begin : g_bad_nch
    $error("gated_delay_mux: NCH must be >= 2");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("gated_delay_mux: DEPTH must be >= 1");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("gated_delay_mux: HOLD must be in 1..255");
  end

  logic [NCH*W-1:0]   w_data_tail;
  logic [c_sel_w-1:0] w_sel_tail;
  logic               w_valid_tail;
  logic               w_cond_tail;

  gdm_delay_line #(.WIDTH(NCH*W), .DEPTH(DEPTH)) u_dl_data (
    .clk(clk), .rst(rst), .i_d(in_data), .o_q(w_data_tail)
  );
  gdm_delay_line #(.WIDTH(c_sel_w), .DEPTH(DEPTH)) u_dl_sel (
    .clk(clk), .rst(rst), .i_d(sel), .o_q(w_sel_tail)
  );
  gdm_delay_line #(.WIDTH(1), .DEPTH(DEPTH)) u_dl_valid (
    .clk(clk), .rst(rst), .i_d(in_valid), .o_q(w_valid_tail)
  );
  gdm_delay_line #(.WIDTH(1), .DEPTH(DEPTH)) u_dl_cond (
    .clk(clk), .rst(rst), .i_d(cond), .o_q(w_cond_tail)
  );

  // Out-of-range selects fall through to channel 0.
  logic [W-1:0] w_pick;
  always_comb begin
    w_pick = w_data_tail[W-1:0];
    for (int k = 1; k < NCH; k++) begin
      if (w_sel_tail == c_sel_w'(k)) begin
        w_pick = w_data_tail[k*W +: W];
      end
    end
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_blank;

`ifdef GATED_DELAY_MUX_HOLD_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // The BLANK cycle in which cond falls is the first of the HOLD hold cycles;
  // r_cnt then counts the DRAIN cycles still to go.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      PASS: begin
        if (w_cond_tail) w_state_nxt = BLANK;
      end
      BLANK: begin
        if (!w_cond_tail) begin
          if (HOLD > 1) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = CNT_W'(HOLD - 1);
          end else begin
            w_state_nxt = PASS;
          end
        end
      end
      DRAIN: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (w_cond_tail) begin
          w_state_nxt = BLANK;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = PASS;
        end
      end
      default: w_state_nxt = PASS;
    endcase
  end

  assign w_blank = w_cond_tail || (r_state != PASS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  // Without hold-off, BLANK only records that the previous tail was blanked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PASS:    if (w_cond_tail)  w_state_nxt = BLANK;
      BLANK:   if (!w_cond_tail) w_state_nxt = PASS;
      default: w_state_nxt = PASS;
    endcase
  end

  assign w_blank = w_cond_tail;
`endif

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_blanked;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PASS;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_blanked   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_valid_tail;
      r_out_data  <= w_blank ? '0 : w_pick;
      r_blanked   <= w_blank;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign blanked   = r_blanked;

endmodule
`default_nettype wire

// File: tb/tb_gated_delay_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gated_delay_mux                                                         |
// | Randomised bench with a queue-based reference model plus literal pins.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gated_delay_mux;

  localparam int W     = 8;
  localparam int NCH   = 4;
  localparam int DEPTH = 2;
  localparam int HOLD  = 3;
  localparam int SW    = 2;
  localparam int LAT   = DEPTH + 1;
`ifdef GATED_DELAY_MUX_HOLD_EN
  localparam int HOLD_EFF = HOLD;
`else
  localparam int HOLD_EFF = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             cond = 1'b0;
  logic [NCH*W-1:0] in_data = '0;
  logic [SW-1:0]    sel = '0;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             blanked;

  logic [3*W-1:0]   in_data3 = '0;
  logic [1:0]       sel3 = '0;
  logic             out_valid3;
  logic [W-1:0]     out_data3;
  logic             blanked3;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  gated_delay_mux #(.W(W), .NCH(NCH), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel),
    .cond(cond), .out_valid(out_valid), .out_data(out_data), .blanked(blanked)
  );

  gated_delay_mux #(.W(W), .NCH(3), .DEPTH(DEPTH), .HOLD(HOLD)) dut3 (
    .clk(clk), .rst(rst), .in_valid(1'b1), .in_data(in_data3), .sel(sel3),
    .cond(1'b0), .out_valid(out_valid3), .out_data(out_data3), .blanked(blanked3)
  );

  // Reference model: beats wait DEPTH edges in a queue, then the output register
  // takes the tail. Blanking holds while fewer than HOLD_EFF+1 beats since last cond.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [SW-1:0]    s;
    logic [NCH*W-1:0] d;
  } beat_t;

  beat_t        pipe[$];
  beat_t        t_in;
  beat_t        t_out;
  logic         exp_v = 1'b0;
  logic         exp_b = 1'b0;
  logic [W-1:0] exp_d = '0;
  int           since = 1000;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pipe.delete();
      for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
      exp_v = 1'b0;
      exp_d = '0;
      exp_b = 1'b0;
      since = 1000;
      model_live = 1'b1;
    end else if (model_live) begin
      t_out = pipe.pop_front();
      if (t_out.c) since = 0;
      else if (since < 1000) since = since + 1;
      exp_b = (since <= HOLD_EFF);
      exp_v = t_out.v;
      if (exp_b) exp_d = '0;
      else if (int'(t_out.s) < NCH) exp_d = t_out.d[int'(t_out.s)*W +: W];
      else exp_d = t_out.d[W-1:0];
      t_in = '{v: in_valid, c: cond, s: sel, d: in_data};
      pipe.push_back(t_in);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      n_cmp++;
      if (out_valid !== exp_v || out_data !== exp_d || blanked !== exp_b) begin
        n_bad++;
        $display("FAIL model @%0t: got v=%0b d=%02h b=%0b, want v=%0b d=%02h b=%0b",
                 $time, out_valid, out_data, blanked, exp_v, exp_d, exp_b);
      end
    end
  end

  task automatic lit(input string name, input logic v, input logic [W-1:0] d, input logic b);
    n_cmp++;
    if (out_valid !== v || out_data !== d || blanked !== b) begin
      n_bad++;
      $display("FAIL %s: got v=%0b d=%02h b=%0b, want v=%0b d=%02h b=%0b",
               name, out_valid, out_data, blanked, v, d, b);
    end
  endtask

  task automatic lit3(input string name, input logic [W-1:0] d);
    n_cmp++;
    if (out_valid3 !== 1'b1 || out_data3 !== d || blanked3 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got v=%0b d=%02h b=%0b, want v=1 d=%02h b=0",
               name, out_valid3, out_data3, blanked3, d);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [SW-1:0] s);
    in_valid = v;
    cond     = c;
    sel      = s;
  endtask

  // Directed sequence A: channel values and per-beat expectations.
  int cv[4]      = '{8'h11, 8'h3C, 8'hA5, 8'h77};
  int ta_sel[14] = '{2, 1, 1, 1, 1, 1, 3, 3, 3, 3, 0, 0, 0, 2};
  int ta_cnd[14] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
  int ta_val[14] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
`ifdef GATED_DELAY_MUX_HOLD_EN
  int ta_blk[14] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0};
`else
  int ta_blk[14] = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
`endif

  initial begin
    int           bi;
    logic [W-1:0] ed;
    in_data3 = {8'h33, 8'h22, 8'h11};
    sel3     = 2'd3;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset_state", 1'b0, 8'h00, 1'b0);
    rst     = 1'b0;
    in_data = {8'h77, 8'hA5, 8'h3C, 8'h11};

    for (int m = 0; m < 14 + LAT; m++) begin
      if (m >= LAT) begin
        bi = m - LAT;
        ed = (ta_blk[bi] != 0) ? 8'h00 : W'(cv[ta_sel[bi]]);
        lit($sformatf("dirA_beat%0d", bi), ta_val[bi] != 0, ed, ta_blk[bi] != 0);
      end
      if (m < 14) drive(ta_val[m] != 0, ta_cnd[m] != 0, SW'(ta_sel[m]));
      else        drive(1'b0, 1'b0, 2'd0);
      @(negedge clk);
    end

    // Sequence B: reset pulsed while blanking is being held.
    for (int m = 0; m < 10; m++) begin
      rst = (m == 5);
      case (m)
        0:       drive(1'b1, 1'b1, 2'd1);
        1, 2, 3: drive(1'b1, 1'b0, 2'd1);
        5:       drive(1'b1, 1'b0, 2'd1);
        6:       drive(1'b1, 1'b0, 2'd2);
        default: drive(1'b0, 1'b0, 2'd0);
      endcase
      if (m == 3) lit("dirB_cond_beat", 1'b1, 8'h00, 1'b1);
      if (m == 4) lit("dirB_fall_beat", 1'b1, (HOLD_EFF > 0) ? 8'h00 : 8'h3C, HOLD_EFF > 0);
      if (m >= 6 && m <= 8) lit($sformatf("dirB_post_reset%0d", m - 6), 1'b0, 8'h00, 1'b0);
      if (m == 9) lit("dirB_first_new_beat", 1'b1, 8'hA5, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;

    lit3("nch3_sel3_falls_to_ch0", 8'h11);
    sel3 = 2'd2;
    repeat (LAT) @(negedge clk);
    lit3("nch3_sel2", 8'h33);

    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 249) == 0);
      in_valid = 1'($urandom_range(0, 1));
      cond     = ($urandom_range(0, 5) == 0);
      sel      = SW'($urandom_range(0, NCH - 1));
      in_data  = (NCH*W)'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0);
    repeat (LAT + HOLD + 2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gated_delay_mux.md
GATED_DELAY_MUX -- requirements
Module: gated_delay_mux

Interface
REQ-001 Parameter W, default 8: data width per channel in bits.
REQ-002 Parameter NCH, default 4: number of input channels (>=2).
REQ-003 Parameter DEPTH, default 2: input delay stages (>=1).
REQ-004 Parameter HOLD, default 3: post-blank drain cycles (>=1, <=255).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 in_valid  in  1  input beat qualifier.
REQ-008 in_data  in  NCH*W  packed channels; channel k occupies bits [k*W +: W].
REQ-009 sel  in  $clog2(NCH)  channel select for the beat.
REQ-010 cond  in  1  sanitise request; zeroes aligned output data.
REQ-011 out_valid  out  1  output beat qualifier.
REQ-012 out_data  out  W  selected channel data, or zero when blanked.
REQ-013 blanked  out  1  high when the current output beat was forced to zero.

Function
REQ-014 in_data, sel, in_valid and cond SHALL each pass through an identical DEPTH-stage shift register, keeping them cycle-aligned; the last stage is "tail".
REQ-015 Stages SHALL shift every cycle; there is no backpressure.
REQ-016 The output register SHALL load every cycle, giving a total input-to-output latency of exactly DEPTH+1 cycles.
REQ-017 out_valid SHALL equal the registered valid_tail.
REQ-018 sel_tail >= NCH SHALL select channel 0.
REQ-019 The FSM SHALL have states PASS, BLANK and DRAIN, and SHALL reset to PASS.
REQ-020 Blank condition = cond_tail OR state != PASS; when true, out_data SHALL load 0 and blanked SHALL load 1; otherwise out_data SHALL load data_tail[sel_tail] and blanked SHALL load 0.
REQ-021 PASS SHALL go to BLANK when cond_tail=1; otherwise it SHALL stay in PASS.
REQ-022 BLANK SHALL stay in BLANK while cond_tail=1; when cond_tail=0 it SHALL go to DRAIN and load cnt=HOLD-1 (HOLD_EN set), or go to PASS (HOLD_EN clear).
REQ-023 DRAIN SHALL decrement cnt every cycle regardless of valid; cond_tail=1 SHALL return it to BLANK (cnt abandoned), which takes priority over cnt==0; cnt==0 SHALL go to PASS.
REQ-024 blanked and out_data blanking SHALL apply whether or not valid_tail is set; invalid beats SHALL still carry data or zero per REQ-020.
REQ-025 cnt SHALL be 8 bits wide; the DEPTH and HOLD parameter ranges SHALL be asserted at elaboration.

Reset
REQ-026 While rst=1, all delay stages, out_valid, out_data, blanked and cnt SHALL clear to 0, and state SHALL clear to PASS.
REQ-027 Reset asserted mid-blank or mid-drain SHALL abort the sequence; the first post-reset output SHALL be unblanked zero data with out_valid=0.
REQ-028 Beats in flight at reset SHALL be discarded and never emitted.

Configuration
REQ-029 Macro GATED_DELAY_MUX_HOLD_EN defined: DRAIN and cnt SHALL be implemented, and blanking SHALL persist HOLD cycles after cond_tail falls.
REQ-030 Macro undefined: cnt and DRAIN SHALL be omitted, BLANK SHALL exit directly to PASS, and blanking SHALL track cond_tail exactly, as in the single-cycle predecessor.

Structure
REQ-031 Package gated_delay_mux_pkg SHALL hold the state enum (PASS, BLANK, DRAIN), the cnt width constant CNT_W=8 and the default parameter values.
REQ-032 Sub-module gdm_delay_line (parametrised width and depth, synchronous clear) SHALL implement each shift register of REQ-014.
REQ-033 Annotation hooks: in_data and cond are taint sources, out_data is the sink, and cond and the FSM state are sanitised.

Verification
REQ-034 Defaults, cond=0, in_valid=1, sel=2, channel 2 = 0xA5 -> out_data=0xA5 and out_valid=1 exactly 3 cycles later, blanked=0.
REQ-035 cond=1 for one beat (channel 1 = 0x3C, sel=1) with HOLD_EN set -> that beat and the next 3 output cycles have out_data=0 and blanked=1; the 5th beat passes data.
REQ-036 Same stimulus as REQ-035 without HOLD_EN -> only the aligned beat is zeroed; the next beat passes data.
REQ-037 cond pulses on beats 0 and 2 (HOLD_EN, HOLD=3) -> output stays blanked for beats 0 through 5, then passes data.
REQ-038 rst pulsed for 1 cycle during DRAIN -> outputs zero with out_valid=0 until new beats reach the tail; the first new beat is unblanked.
REQ-039 NCH=3, sel=3, channel 0 = 0x11 -> out_data=0x11 (out-of-range select falls back to channel 0).
